// File: rtl/ret_addr_stack_if.sv
// rtl/ret_addr_stack_if.sv - call/ret request and top-of-stack bundle for ret_addr_stack
// master drives the fetch-side requests; slave is the stack itself.
interface ret_addr_stack_if #(
  parameter int AW = 16
);
  logic          call;
  logic          ret;
  logic          halt;
  logic [AW-1:0] pc;
  logic [AW-1:0] ret_addr;
  logic          empty;
  logic          full;
  logic          ovf_err;
  logic          unf_err;

  modport master (
    output call, ret, halt, pc,
    input  ret_addr, empty, full, ovf_err, unf_err
  );

  modport slave (
    input  call, ret, halt, pc,
    output ret_addr, empty, full, ovf_err, unf_err
  );
endinterface

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - hardware return-address stack with combinational top-of-stack
// Define RET_ADDR_STACK_WRAP_EN to make push-while-full overwrite the oldest entry.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  ret_addr_stack_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH);
  localparam logic [SPW:0] FULL_CNT = (SPW+1)'(DEPTH);

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW:0]   cnt;

  logic [SPW-1:0] top_idx;
  logic [AW-1:0]  push_val;
  logic           is_empty;
  logic           is_full;

  logic           wr_en;
  logic [SPW-1:0] wr_idx;
  logic [SPW-1:0] sp_nxt;
  logic [SPW:0]   cnt_nxt;
  logic           unf_set;
  logic           unf_q;
`ifndef RET_ADDR_STACK_WRAP_EN
  logic           ovf_set;
  logic           ovf_q;
`endif

  // sp is exactly log2(DEPTH) bits, so sp-1 and sp+1 wrap for free
  assign top_idx  = sp - 1'b1;
  assign push_val = bus.pc + 1'b1;
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp;
    sp_nxt  = sp;
    cnt_nxt = cnt;
    unf_set = 1'b0;
`ifndef RET_ADDR_STACK_WRAP_EN
    ovf_set = 1'b0;
`endif
    if (!bus.halt) begin
      case ({bus.call, bus.ret})
        2'b10: begin
          if (!is_full) begin
            wr_en   = 1'b1;
            sp_nxt  = sp + 1'b1;
            cnt_nxt = cnt + 1'b1;
          end else begin
`ifdef RET_ADDR_STACK_WRAP_EN
            wr_en  = 1'b1;
            sp_nxt = sp + 1'b1;
`else
            ovf_set = 1'b1;
`endif
          end
        end
        2'b01: begin
          if (!is_empty) begin
            sp_nxt  = sp - 1'b1;
            cnt_nxt = cnt - 1'b1;
          end else begin
            unf_set = 1'b1;
          end
        end
        2'b11: begin
          // call+ret together replaces the top; on an empty stack it degrades to a push
          if (!is_empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end else begin
            wr_en   = 1'b1;
            sp_nxt  = sp + 1'b1;
            cnt_nxt = cnt + 1'b1;
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sp    <= '0;
      cnt   <= '0;
      unf_q <= 1'b0;
`ifndef RET_ADDR_STACK_WRAP_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      if (wr_en) mem[wr_idx] <= push_val;
      sp  <= sp_nxt;
      cnt <= cnt_nxt;
      if (unf_set) unf_q <= 1'b1;
`ifndef RET_ADDR_STACK_WRAP_EN
      if (ovf_set) ovf_q <= 1'b1;
`endif
    end
  end

  assign bus.ret_addr = is_empty ? '0 : mem[top_idx];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.unf_err  = unf_q;
`ifdef RET_ADDR_STACK_WRAP_EN
  assign bus.ovf_err  = 1'b0;
`else
  assign bus.ovf_err  = ovf_q;
`endif
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb/tb_ret_addr_stack.sv - directed self-checking bench for ret_addr_stack
// Expected values are hand-computed; wrap-build expectations follow RET_ADDR_STACK_WRAP_EN.
module tb_ret_addr_stack;
  localparam int AW    = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ret_addr_stack_if #(.AW(AW)) bus ();

  ret_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.call = 1'b0;
    bus.ret  = 1'b0;
    bus.halt = 1'b0;
  endtask

  // inputs change 1ns after the rising edge and are sampled at the next one
  task automatic op(input logic c, input logic r, input logic h, input logic [AW-1:0] p);
    bus.call = c;
    bus.ret  = r;
    bus.halt = h;
    bus.pc   = p;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp2 [3];
    exp2 = '{41, 21, 6};
    bus.pc = '0;
    idle();

    // 1: reset held with random call/ret
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.call = 1'($urandom_range(0, 1));
      bus.ret  = 1'($urandom_range(0, 1));
      bus.pc   = 16'($urandom);
      @(posedge clk);
      #1;
      check("rst_ret_addr", 32'(bus.ret_addr), 0);
      check("rst_empty",    32'(bus.empty),    1);
      check("rst_full",     32'(bus.full),     0);
      check("rst_ovf",      32'(bus.ovf_err),  0);
      check("rst_unf",      32'(bus.unf_err),  0);
    end
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: push/pop order
    op(1'b1, 1'b0, 1'b0, 16'd5);
    op(1'b1, 1'b0, 1'b0, 16'd20);
    op(1'b1, 1'b0, 1'b0, 16'd40);
    check("order_top", 32'(bus.ret_addr), 41);
    for (int i = 0; i < 3; i++) begin
      bus.ret = 1'b1;
      #1;
      check("order_pop", 32'(bus.ret_addr), 32'(exp2[i]));
      @(posedge clk);
      #1;
      idle();
    end
    check("order_empty",    32'(bus.empty),    1);
    check("order_ret_addr", 32'(bus.ret_addr), 0);

    // 3/4: fill to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_not_full", 32'(bus.full), 0);
      op(1'b1, 1'b0, 1'b0, 16'(i));
    end
    check("fill_full", 32'(bus.full), 1);
    check("fill_ovf_clear", 32'(bus.ovf_err), 0);
`ifdef RET_ADDR_STACK_WRAP_EN
    op(1'b1, 1'b0, 1'b0, 16'd8);
    op(1'b1, 1'b0, 1'b0, 16'd9);
    check("wrap_full", 32'(bus.full),    1);
    check("wrap_ovf",  32'(bus.ovf_err), 0);
    check("wrap_top",  32'(bus.ret_addr), 10);
    for (int i = 0; i < DEPTH; i++) begin
      check("wrap_pop", 32'(bus.ret_addr), 32'(10 - i));
      op(1'b0, 1'b1, 1'b0, 16'd0);
    end
`else
    op(1'b1, 1'b0, 1'b0, 16'd8);
    check("ovf_full", 32'(bus.full),    1);
    check("ovf_set",  32'(bus.ovf_err), 1);
    check("ovf_top",  32'(bus.ret_addr), 8);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_pop", 32'(bus.ret_addr), 32'(8 - i));
      op(1'b0, 1'b1, 1'b0, 16'd0);
    end
`endif
    check("drain_empty", 32'(bus.empty),   1);
    check("drain_unf",   32'(bus.unf_err), 0);

    // 5: pc+1 wraparound and replace-top
    do_reset();
    op(1'b1, 1'b0, 1'b0, 16'hFFFF);
    check("wrap_pc_top",   32'(bus.ret_addr), 0);
    check("wrap_pc_empty", 32'(bus.empty),    0);
    op(1'b0, 1'b1, 1'b0, 16'd0);
    op(1'b1, 1'b0, 1'b0, 16'd5);
    check("repl_before", 32'(bus.ret_addr), 6);
    bus.call = 1'b1;
    bus.ret  = 1'b1;
    bus.pc   = 16'd30;
    #1;
    check("repl_same_cycle", 32'(bus.ret_addr), 6);
    @(posedge clk);
    #1;
    idle();
    check("repl_after", 32'(bus.ret_addr), 31);
    op(1'b0, 1'b1, 1'b0, 16'd0);
    check("repl_count", 32'(bus.empty),   1);
    check("repl_unf",   32'(bus.unf_err), 0);

    // 6: halt, underflow, async reset
    do_reset();
    op(1'b1, 1'b0, 1'b0, 16'd3);
    op(1'b1, 1'b0, 1'b1, 16'd7);
    check("halt_call", 32'(bus.ret_addr), 4);
    op(1'b0, 1'b1, 1'b1, 16'd0);
    check("halt_ret",  32'(bus.ret_addr), 4);
    check("halt_empty", 32'(bus.empty),   0);
    op(1'b0, 1'b1, 1'b0, 16'd0);
    op(1'b0, 1'b1, 1'b0, 16'd0);
    check("unf_set",   32'(bus.unf_err), 1);
    check("unf_empty", 32'(bus.empty),   1);
    check("unf_ovf",   32'(bus.ovf_err), 0);
    op(1'b1, 1'b1, 1'b0, 16'd9);
    check("empty_repl_top",   32'(bus.ret_addr), 10);
    check("empty_repl_empty", 32'(bus.empty),    0);
    check("empty_repl_unf",   32'(bus.unf_err),  1);
    op(1'b1, 1'b0, 1'b0, 16'd11);
    rst = 1'b1;
    #2;
    check("async_empty",    32'(bus.empty),    1);
    check("async_ret_addr", 32'(bus.ret_addr), 0);
    check("async_unf",      32'(bus.unf_err),  0);
    check("async_full",     32'(bus.full),     0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_empty", 32'(bus.empty), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
